// File: rtl/spi_read_pkg.sv
// Shared definitions for the SPI read sequencer.
// Holds the state encoding and the default frame geometry.
package spi_read_pkg;
  localparam int DEF_FRAME_BITS = 50;
  localparam int DEF_SKIP_BITS  = 18;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_GAP_TICKS  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SHIFT,
    S_STORE,
    S_GAP
  } state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_read_sipo.sv
// Serial-in parallel-out register for the SPI read sequencer.
// Bits enter at the LSB so the first bit ends up as the MSB.
module spi_read_sipo
  import spi_read_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr,
  input  logic              shift,
  input  logic              din,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift) begin
      q <= (q << 1) | DATA_W'(din);
    end
  end

endmodule

// File: rtl/spi_read_seq.sv
// SPI read sequencer: frames NUM_CH conversions, drops the leading
// SKIP_BITS clocks and presents one MSB-first word per channel.
module spi_read_seq
  import spi_read_pkg::*;
#(
  parameter  int FRAME_BITS = DEF_FRAME_BITS,
  parameter  int SKIP_BITS  = DEF_SKIP_BITS,
  parameter  int NUM_CH     = DEF_NUM_CH,
  parameter  int GAP_TICKS  = DEF_GAP_TICKS,
  localparam int DATA_W     = FRAME_BITS - SKIP_BITS,
  localparam int CNT_W      = $clog2(FRAME_BITS),
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              strr_i,
  input  logic              cont_i,
  input  logic              abort_i,
  input  logic              slow_clk_i,
  input  logic              miso_i,
  output logic              frame_o,
  output logic [CH_W-1:0]   ch_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              eor_o,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] FIRST_DATA = CNT_W'(SKIP_BITS);
  localparam logic [CNT_W-1:0] LAST_GAP   = CNT_W'(GAP_TICKS - 1);
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   ch_d;
  logic              frame_d;
  logic              valid_d;
  logic              eor_d;
  logic              load;
  logic              sipo_clr;
  logic              sipo_shift;
  logic [DATA_W-1:0] sipo_q;
  logic [DATA_W-1:0] capture;

  spi_read_sipo #(
    .DATA_W(DATA_W)
  ) u_sipo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr  (sipo_clr),
    .shift(sipo_shift),
    .din  (miso_i),
    .q    (sipo_q)
  );

  assign sipo_clr   = (state_q != S_SHIFT);
  assign sipo_shift = (state_q == S_SHIFT) && slow_clk_i
                      && (cnt_q >= FIRST_DATA);
  // word including the LSB being sampled on this tick
  assign capture    = (sipo_q << 1) | DATA_W'(miso_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (strr_i) state_d = S_ARM;
      S_ARM:   state_d = S_SHIFT;
      S_SHIFT: if (slow_clk_i && cnt_q == LAST_BIT) state_d = S_STORE;
      S_STORE: state_d = (ch_q != LAST_CH || cont_i) ? S_GAP : S_IDLE;
      S_GAP:   if (slow_clk_i && cnt_q == LAST_GAP) state_d = S_ARM;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  always_comb begin
    frame_d = (state_d == S_SHIFT);
    valid_d = (state_d == S_STORE);
    eor_d   = (state_d == S_IDLE);
    load    = (state_d == S_STORE);
  end

  always_comb begin
    cnt_d = '0;
    ch_d  = ch_q;
    unique case (state_q)
      S_IDLE: ch_d = '0;
      S_SHIFT: begin
        if (slow_clk_i) cnt_d = (cnt_q == LAST_BIT) ? '0 : cnt_q + 1'b1;
        else cnt_d = cnt_q;
      end
      S_STORE: ch_d = (ch_q != LAST_CH) ? ch_q + 1'b1 : '0;
      S_GAP: begin
        if (slow_clk_i) cnt_d = (cnt_q == LAST_GAP) ? '0 : cnt_q + 1'b1;
        else cnt_d = cnt_q;
      end
      default: cnt_d = '0;
    endcase
    if (abort_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      ch_q    <= '0;
      frame_o <= 1'b0;
      valid_o <= 1'b0;
      eor_o   <= 1'b1;
      data_o  <= '0;
      ch_o    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      frame_o <= frame_d;
      valid_o <= valid_d;
      eor_o   <= eor_d;
      if (load) begin
        data_o <= capture;
        ch_o   <= ch_q;
      end
    end
  end

  assign busy_o = ~eor_o;

endmodule
